// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Contents: FSM state enum, default dividend/divisor widths, counter width.
package div_pkg;

  localparam int unsigned DIV_DW = 16;
  localparam int unsigned DIV_VW = 8;
  localparam int unsigned DIV_CW = $clog2(DIV_DW + 1);

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle of the restoring divider.
// master: drives start_i, dividend_i, divisor_i; observes busy_o, done_o, quotient_o,
//         remainder_o, dbz_o.
// slave:  the divider side of the same signals.
interface restoring_divider_if #(
  parameter int unsigned DW = div_pkg::DIV_DW,
  parameter int unsigned VW = div_pkg::DIV_VW
);
  logic          start_i;
  logic [DW-1:0] dividend_i;
  logic [VW-1:0] divisor_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] quotient_o;
  logic [VW-1:0] remainder_o;
  logic          dbz_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, dbz_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, dbz_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports: rem (partial remainder), dvd_bit (next dividend MSB), divisor in;
//        new_rem, qbit out.
module div_step #(
  parameter int unsigned VW = div_pkg::DIV_VW
) (
  input  logic [VW-1:0] rem,
  input  logic          dvd_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] new_rem,
  output logic          qbit
);

  logic [VW:0] p;
  logic [VW:0] diff;

  // rem < divisor holds between steps, so the difference always fits in VW bits.
  always_comb begin
    p       = {rem, dvd_bit};
    diff    = p - {1'b0, divisor};
    qbit    = (p >= {1'b0, divisor});
    new_rem = qbit ? diff[VW-1:0] : p[VW-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Ports: wb_clk_i, wb_rst_ni (async active-low), bus (restoring_divider_if.slave):
//   start_i/dividend_i/divisor_i request; busy_o, done_o pulse, quotient_o, remainder_o, dbz_o.
// Build option: DIV_ZERO_FAST_EN -- a zero divisor completes in one cycle without entering RUN.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  restoring_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dq_q, dq_d;     // dividend shifts out of the MSB, quotient shifts into the LSB
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [VW-1:0] step_rem;
  logic          step_qbit;
  logic [DW-1:0] step_dq;
  logic          fast_zero;

  div_step #(.VW(VW)) u_step (
    .rem     (rem_q),
    .dvd_bit (dq_q[DW-1]),
    .divisor (dvs_q),
    .new_rem (step_rem),
    .qbit    (step_qbit)
  );

  assign step_dq = {dq_q[DW-2:0], step_qbit};

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (bus.divisor_i == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start_i) begin
          if (fast_zero) begin
            quo_d  = '1;
            remo_d = bus.dividend_i[VW-1:0];
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = DIV_RUN;
            cnt_d   = CW'(DW);
            dq_d    = bus.dividend_i;
            dvs_d   = bus.divisor_i;
            rem_d   = '0;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q - CW'(1);
        // Last step: publish results straight from the step so latency is exactly DW.
        if (cnt_q == CW'(1)) begin
          state_d = DIV_IDLE;
          done_d  = 1'b1;
          dbz_d   = (dvs_q == '0);
          // A zero divisor makes every step take qbit=1 and keep the low VW dividend
          // bits as remainder; the quotient is forced regardless.
          quo_d   = (dvs_q == '0) ? '1 : step_dq;
          remo_d  = step_rem;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    busy_d = (state_d == DIV_RUN);
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.quotient_o  = quo_q;
  assign bus.remainder_o = remo_q;
  assign bus.dbz_o       = dbz_q;

endmodule
